eqn_cmp_seq: RTL

- Parametrised, clocked successor of the 2-bit equality comparator.
- Compares two W-bit operand streams, one sample pair per handshake, over a block of LEN samples.
- Per sample, produces registered eq/gt/lt flags.
- Per block, accumulates a saturating mismatch count and the index of the first mismatch.
- Sits between a vector source (testbench memory or on-chip stimulus ROM) and a result logger or status register.

---
 rtl/eqn_cmp_pkg.sv | 17 +
 rtl/eqn_cmp_core.sv | 21 ++
 rtl/eqn_cmp_seq.sv | 83 ++++++++
 3 files changed

// File: rtl/eqn_cmp_pkg.sv
// eqn_cmp_pkg: shared state encoding and sizing helper for the eqn_cmp_seq block.
package eqn_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/eqn_cmp_core.sv
// eqn_cmp_core: combinational W-bit magnitude comparator.
// Define EQN_CMP_SIGNED_EN to make gt/lt treat operands as two's-complement.
module eqn_cmp_core #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

`ifdef EQN_CMP_SIGNED_EN
    assign gt = $signed(a) > $signed(b);
`else
    assign gt = a > b;
`endif
    assign eq = a == b;
    assign lt = !eq && !gt;

endmodule

// File: rtl/eqn_cmp_seq.sv
// eqn_cmp_seq: block-wise streaming comparator with per-sample flags and per-block mismatch statistics.
// Define EQN_CMP_SIGNED_EN for signed gt/lt ordering.
module eqn_cmp_seq
    import eqn_cmp_pkg::*;
#(
    parameter  int W   = 2,
    parameter  int LEN = 8,
    parameter  int CW  = 8,
    localparam int IW  = clog2(LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    output logic          aeqb,
    output logic          agtb,
    output logic          altb,
    output logic [CW-1:0] mism_cnt,
    output logic          any_mism,
    output logic [IW-1:0] first_idx,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic          eq, gt, lt, acc, last;

    eqn_cmp_core #(.W(W)) u_core (.a(a), .b(b), .eq(eq), .gt(gt), .lt(lt));

    assign in_ready = state == RUN;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign acc      = in_valid && in_ready;
    assign last     = idx == IW'(LEN - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN)  ? ((acc && last) ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            aeqb      <= 1'b0;
            agtb      <= 1'b0;
            altb      <= 1'b0;
            mism_cnt  <= '0;
            any_mism  <= 1'b0;
            first_idx <= '0;
        end else begin
            out_valid <= acc;
            if (state == IDLE && start) begin
                idx       <= '0;
                mism_cnt  <= '0;
                any_mism  <= 1'b0;
                first_idx <= '0;
            end
            if (acc) begin
                {aeqb, agtb, altb} <= {eq, gt, lt};
                idx <= last ? '0 : idx + IW'(1);
                if (!eq) begin
                    // saturate rather than wrap so a long mismatch run never reads as clean
                    mism_cnt <= mism_cnt + CW'(mism_cnt != '1);
                    if (!any_mism) begin
                        any_mism  <= 1'b1;
                        first_idx <= idx;
                    end
                end
            end
        end
    end

endmodule
